// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the 16-bit data memory port.
//   - state_e        : controller state encoding
//   - ADDR_W_DEF     : default address width
//   - DATA_W_DEF     : default data width
//   - MEM_RD_LAT_MAX : largest supported read latency in cycles
package mem_if_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned MEM_RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_WAIT   = 3'd4,
    R_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_master.sv
// mem_access_master: initiator side of the data memory port.
// Turns CPU load/store requests into mem_addr/mem_wdata/mem_wEn activity on a
// level-sensitive memory and returns load beats to the CPU.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_len         : request fields, captured on acceptance
//   rsp_valid/rsp_data/rsp_last: one-cycle load beat response
//   mem_addr/mem_wdata/mem_wEn : registered memory-side outputs
//   mem_rdata                  : memory read data (combinational from mem_addr)
//   busy                       : high whenever not IDLE
module mem_access_master
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wEn,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(MEM_RD_LAT_MAX);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  state_e              state_r;
  state_e              state_nx_s;
  logic                accept_s;
  logic                lat_last_s;
  logic                beat_last_s;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic [LEN_W-1:0]    beat_cnt_r;
  logic [LEN_W-1:0]    len_r;
  logic                req_ready_r;
  logic                busy_r;
  logic                rsp_valid_r;
  logic                rsp_last_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_wen_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and acceptance decode.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    lat_last_s  = (lat_cnt_r == LAT_LAST);
    beat_last_s = (beat_cnt_r == len_r);
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s   = 1'b1;
          state_nx_s = req_write ? W_SETUP : R_WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      W_SETUP:  state_nx_s = W_STROBE;
      W_STROBE: state_nx_s = W_HOLD;
      W_HOLD:   state_nx_s = IDLE;
      R_WAIT: begin
        if (lat_last_s) begin
          state_nx_s = R_RESP;
        end else begin
          state_nx_s = R_WAIT;
        end
      end
      R_RESP: begin
        if (beat_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = R_WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Registered outputs and counters; status flags are derived from the next
  // state so that they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= '0;
      lat_cnt_r   <= '0;
      beat_cnt_r  <= '0;
      len_r       <= '0;
    end else begin
      req_ready_r <= (state_nx_s == IDLE);
      busy_r      <= (state_nx_s != IDLE);
      mem_wen_r   <= (state_nx_s == W_STROBE);
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mem_addr_r  <= req_addr;
            mem_wdata_r <= req_wdata;
            len_r       <= req_write ? '0 : req_len;
            beat_cnt_r  <= '0;
            lat_cnt_r   <= '0;
          end
        end
        R_WAIT: begin
          if (lat_last_s) begin
            rsp_data_r  <= mem_rdata;
            rsp_valid_r <= 1'b1;
            rsp_last_r  <= beat_last_s;
            lat_cnt_r   <= '0;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1);
          end
        end
        R_RESP: begin
          // Address wraps modulo 2^ADDR_W by plain overflow.
          if (!beat_last_s) begin
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign mem_wEn   = mem_wen_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_last  = rsp_last_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: scoreboard bench for mem_access_master (RD_LAT = 1).
// Stimulus pushes expected load beats / memory writes into queues; a monitor
// pops and compares whenever the DUT pulses rsp_valid or mem_wEn.
module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [3:0]  req_len = 4'h0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wEn;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [15:0] addr;
    int          cyc;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] wq[$];

  // Behavioural memory block plus a bench-side preload port.
  logic [15:0] mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [15:0] pre_data = 16'h0000;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wEn) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mem_access_master #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wEn(mem_wEn),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: compare every response beat and every write strobe.
  initial begin
    rsp_t        e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          e = rq.pop_front();
          check("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
          check("rsp_last", {31'h0, rsp_last}, {31'h0, e.last});
          check("rsp_mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
          check("rsp_cycle", cyc_cnt, e.cyc);
        end
      end else if (rsp_last) begin
        check("rsp_last_without_valid", 32'd1, 32'd0);
      end
      if (mem_wEn) begin
        if (wq.size() == 0) begin
          check("unexpected_mem_wEn", 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          check("wr_addr", {16'h0, mem_addr}, {16'h0, w[31:16]});
          check("wr_data", {16'h0, mem_wdata}, {16'h0, w[15:0]});
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] len, output int c0);
    @(negedge clk);
    check("req_ready_before_req", {31'h0, req_ready}, 32'd1);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    c0 = cyc_cnt;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'h0, req_ready}, 32'd1);
  endtask

  task automatic push_rsp(input logic [15:0] d, input logic l, input logic [15:0] a, input int c);
    rsp_t e;
    e.data = d;
    e.last = l;
    e.addr = a;
    e.cyc  = c;
    rq.push_back(e);
  endtask

  initial begin
    int c0;
    logic [15:0] bdat [4];
    logic [15:0] badr [4];
    bdat = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    badr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_mem_wEn", {31'h0, mem_wEn}, 32'd0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);

    preload(16'h0020, 16'hAAAA);

    // Store 0xBEEF to 0x0010 with cycle-accurate strobe checks.
    wq.push_back({16'h0010, 16'hBEEF});
    do_req(1'b1, 16'h0010, 16'hBEEF, 4'h0, c0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        check("st_mem_wEn", {31'h0, mem_wEn}, (c == 2) ? 32'd1 : 32'd0);
        check("st_mem_addr", {16'h0, mem_addr}, 32'h0010);
        check("st_mem_wdata", {16'h0, mem_wdata}, 32'hBEEF);
        check("st_req_ready", {31'h0, req_ready}, 32'd0);
        check("st_busy", {31'h0, busy}, 32'd1);
      end else begin
        check("st_req_ready_back", {31'h0, req_ready}, 32'd1);
        check("st_busy_back", {31'h0, busy}, 32'd0);
      end
    end
    check("st_mem_content", {16'h0, mem[16'h0010]}, 32'hBEEF);

    // Single load of 0x0010.
    do_req(1'b0, 16'h0010, 16'h0000, 4'h0, c0);
    push_rsp(16'hBEEF, 1'b1, 16'h0010, c0 + 1);
    wait_idle(20);
    check("ld1_queue_drained", rq.size(), 32'd0);

    // Wrapping burst with a store attempted while busy.
    for (int i = 0; i < 4; i++) preload(badr[i], bdat[i]);
    do_req(1'b0, 16'hFFFE, 16'h0000, 4'h3, c0);
    for (int i = 0; i < 4; i++) push_rsp(bdat[i], (i == 3), badr[i], c0 + 2 * i + 1);
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h1234;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle(40);
    check("burst_queue_drained", rq.size(), 32'd0);
    check("busy_store_ignored", {16'h0, mem[16'h0020]}, 32'hAAAA);

    // Re-present the store in IDLE.
    wq.push_back({16'h0020, 16'h1234});
    do_req(1'b1, 16'h0020, 16'h1234, 4'h0, c0);
    wait_idle(20);
    check("represented_store", {16'h0, mem[16'h0020]}, 32'h1234);
    check("wr_queue_drained", wq.size(), 32'd0);

    // Reset during beat 2 of a 4-beat load.
    preload(16'h0100, 16'h0011);
    preload(16'h0101, 16'h0022);
    do_req(1'b0, 16'h0100, 16'h0000, 4'h3, c0);
    push_rsp(16'h0011, 1'b0, 16'h0100, c0 + 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_req_ready", {31'h0, req_ready}, 32'd1);
    check("mrst_busy", {31'h0, busy}, 32'd0);
    check("mrst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("mrst_rsp_data", {16'h0, rsp_data}, 32'd0);
    check("mrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mrst_queue_drained", rq.size(), 32'd0);
    do_req(1'b0, 16'h0101, 16'h0000, 4'h0, c0);
    push_rsp(16'h0022, 1'b1, 16'h0101, c0 + 1);
    wait_idle(20);
    check("post_rst_load_done", rq.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the 16-bit data memory port. Converts CPU load/store requests into `mem_addr`/`mem_wdata`/`mem_wEn` activity on the level-sensitive memory block, and returns load data to the CPU.
- Supports single-word stores and incrementing read bursts of 1..16 words.
- Sits between the CPU datapath/control unit and the memory block.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- RD_LAT, 1, cycles from `mem_addr` stable to `mem_rdata` sampled; legal range 1..4.
- LEN_W, 4, width of burst length field; burst beats = `req_len` + 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  store data.
- req_len  in  LEN_W  load burst beats minus 1; ignored for stores.
- rsp_valid  out  1  one-cycle pulse, load beat valid.
- rsp_data  out  DATA_W  load beat data.
- rsp_last  out  1  final beat of burst, qualified by `rsp_valid`.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wEn  out  1  memory write enable, level.
- mem_rdata  in  DATA_W  memory read data (combinational from `mem_addr`).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - `req_ready` = 1; `busy` = 0.
  - `mem_wEn` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_last` = 0.
  - Beat and latency counters = 0.
  - Reset mid-operation aborts the transfer immediately. `mem_wEn` falls asynchronously. No `rsp_valid` is emitted afterwards.
- Handshake:
  - A request is accepted on a rising edge with `req_valid` && `req_ready`.
  - `req_ready` = 1 only in IDLE. There is no request queue.
  - All request fields are captured into registers on acceptance.
- All memory-side outputs are registered. `mem_wEn` is glitch-free.
- States:
  - IDLE: `req_ready` = 1. On accept, go to W_SETUP if `req_write`, else R_WAIT.
  - W_SETUP (1 cycle): `mem_addr`/`mem_wdata` driven, `mem_wEn` = 0. Next: W_STROBE.
  - W_STROBE (1 cycle): `mem_wEn` = 1, address/data unchanged. Next: W_HOLD.
  - W_HOLD (1 cycle): `mem_wEn` = 0, address/data still held. Next: IDLE.
  - A store therefore occupies exactly 3 cycles after acceptance. Address and data are stable one cycle on each side of the strobe.
  - R_WAIT: `mem_addr` = current beat address. The latency counter counts RD_LAT cycles. On the last count, `mem_rdata` is sampled into `rsp_data`. Next: R_RESP.
  - R_RESP (1 cycle): `rsp_valid` = 1, and `rsp_last` = 1 if the beat counter equals the captured `req_len`.
    - If last, go to IDLE.
    - Otherwise, `mem_addr` increments by 1, the beat counter increments, and the state returns to R_WAIT.
- Timing:
  - Each load beat takes RD_LAT + 1 cycles.
  - A burst of N beats completes N*(RD_LAT+1) cycles after acceptance.
  - There is no response back-pressure; the CPU must sink every `rsp_valid` pulse.
- Address wrap: the burst address increments modulo 2^ADDR_W, so 0xFFFF is followed by 0x0000. No error is flagged.
- `mem_wEn` is never 1 outside W_STROBE.
- `rsp_valid` is never 1 during a store.
- `req_valid` asserted while busy is ignored and has no effect on the transfer in progress.
- Between pulses, `rsp_valid` and `rsp_last` are 0 and `rsp_data` holds its last value.

Decomposition:
- Shared package `mem_if_pkg`:
  - state enum (IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT, R_RESP);
  - ADDR_W/DATA_W defaults;
  - `MEM_RD_LAT_MAX` = 4.
- No sub-module is needed. The latency counter and beat counter stay inline.
- The memory model used for verification is the existing memory block.

Test Plan:
- Reset then idle: `rst_n` = 0 for 2 cycles, release -> `req_ready` = 1, `busy` = 0, `mem_wEn` = 0, `rsp_valid` = 0.
- Store: `req_write` = 1, `addr` = 0x0010, `wdata` = 0xBEEF ->
  - `mem_wEn` = 1 exactly on cycle 2 after accept, with `mem_addr` = 0x0010 and `mem_wdata` = 0xBEEF on cycles 1–3;
  - memory[0x0010] = 0xBEEF;
  - `req_ready` is back to 1 on cycle 4.
- Single load (RD_LAT = 1): memory[0x0010] = 0xBEEF, `req_len` = 0 -> one `rsp_valid` pulse with `rsp_data` = 0xBEEF and `rsp_last` = 1, 2 cycles after accept.
- Wrapping burst: preload memory[0xFFFE..0x0001] = 1,2,3,4; load `addr` = 0xFFFE, `req_len` = 3 -> `rsp_data` sequence 1,2,3,4 every 2 cycles; `rsp_last` only on beat 4; `mem_addr` sequence FFFE, FFFF, 0000, 0001.
- Busy rejection: assert `req_valid` (store to 0x0020) during a burst -> no `mem_wEn` pulse and memory[0x0020] is unchanged until the request is re-presented in IDLE.
- Reset mid-burst: drop `rst_n` during beat 2 of a 4-beat load -> all outputs return to reset values at once, no further `rsp_valid`, and a new request after release completes normally.
